// File: rtl/sys_defs_pkg.sv
// Shared system definitions: bus commands, address width, arbiter states
// and a small population-count helper used for outstanding-load counts.
package sys_defs;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_cmd_t;

  typedef enum logic [0:0] {
    ARB_DPRI   = 1'b0,
    ARB_IFORCE = 1'b1
  } arb_state_t;

  localparam logic OWNER_IC = 1'b0;
  localparam logic OWNER_DC = 1'b1;

  // Tag 0 is never valid, so at most 15 bits can be set and 4 bits suffice.
  function automatic logic [3:0] count_tags(input logic [15:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 16; i++) begin
      n = n + 4'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/mem_arbiter_tag_owner_table.sv
// Tracks which requester owns each outstanding memory load tag.
// Bit 0 of the tables is never written; tags above NUM_TAGS are ignored.
module tag_owner_table
  import sys_defs::*;
#(
  parameter int NUM_TAGS = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       set_en,
  input  logic [3:0] set_tag,
  input  logic       set_owner,
  input  logic [3:0] ret_tag,
  output logic       ret_hit,
  output logic       ret_owner,
  output logic       set_busy,
  output logic [3:0] ic_count,
  output logic [3:0] dc_count
);

  localparam logic [4:0] MAX_TAG = 5'(NUM_TAGS);

  logic [15:0] r_valid;
  logic [15:0] r_owner;
  logic [15:0] w_valid_nxt;
  logic [15:0] w_owner_nxt;
  logic        w_set;
  logic        w_clr;
  logic [3:0]  r_ic_cnt;
  logic [3:0]  r_dc_cnt;

  // Next table contents: the returning tag clears first, a new set wins.
  always_comb begin
    w_clr       = (ret_tag != 4'd0) && r_valid[ret_tag];
    w_set       = set_en && (set_tag != 4'd0) && ({1'b0, set_tag} <= MAX_TAG);
    w_valid_nxt = r_valid;
    w_owner_nxt = r_owner;
    if (w_clr) begin
      w_valid_nxt[ret_tag] = 1'b0;
    end
    if (w_set) begin
      w_valid_nxt[set_tag] = 1'b1;
      w_owner_nxt[set_tag] = set_owner;
    end
  end

  assign ret_hit   = w_clr;
  assign ret_owner = r_owner[ret_tag];
  assign set_busy  = r_valid[set_tag];
  assign ic_count  = r_ic_cnt;
  assign dc_count  = r_dc_cnt;

  // Valid bits and per-owner counts are registered together so they agree.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid  <= '0;
      r_ic_cnt <= 4'd0;
      r_dc_cnt <= 4'd0;
    end else begin
      r_valid  <= w_valid_nxt;
      r_ic_cnt <= count_tags(w_valid_nxt & ~w_owner_nxt);
      r_dc_cnt <= count_tags(w_valid_nxt & w_owner_nxt);
    end
  end

  // Owner bits are only meaningful under a valid bit, so they need no reset.
  always_ff @(posedge clock) begin
    r_owner <= w_owner_nxt;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: dcache priority with an icache
// anti-starvation override, plus tag-based routing of returning load data.
module mem_arbiter
  import sys_defs::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int NUM_TAGS     = 15
) (
  input  logic            clock,
  input  logic            reset,
  input  bus_cmd_t        ic2arb_command,
  input  logic [XLEN-1:0] ic2arb_addr,
  input  bus_cmd_t        dc2arb_command,
  input  logic [XLEN-1:0] dc2arb_addr,
  input  logic [63:0]     dc2arb_data,
  output bus_cmd_t        proc2mem_command,
  output logic [XLEN-1:0] proc2mem_addr,
  output logic [63:0]     proc2mem_data,
  input  logic [3:0]      mem2proc_response,
  input  logic [63:0]     mem2proc_data,
  input  logic [3:0]      mem2proc_tag,
  output logic [3:0]      arb2ic_response,
  output logic [3:0]      arb2dc_response,
  output logic [63:0]     arb2ic_data,
  output logic [63:0]     arb2dc_data,
  output logic [3:0]      arb2ic_tag,
  output logic [3:0]      arb2dc_tag,
  output logic [3:0]      ic_outstanding,
  output logic [3:0]      dc_outstanding,
  output logic            tag_error
);

  localparam logic [3:0] STARVE_LAST = 4'(STARVE_LIMIT - 1);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic [3:0] r_starve_cnt;
  logic [3:0] w_starve_nxt;
  logic       r_tag_error;
  logic       w_err_nxt;
  logic       w_ic_req;
  logic       w_dc_req;
  logic       w_ic_gnt;
  logic       w_dc_gnt;
  logic       w_accept;
  logic       w_load_set;
  logic       w_ret_hit;
  logic       w_ret_owner;
  logic       w_set_busy;

  // Combinational grant selection for the current arbitration state.
  always_comb begin
    w_ic_req = (ic2arb_command != BUS_NONE);
    w_dc_req = (dc2arb_command != BUS_NONE);
    if (r_state == ARB_IFORCE) begin
      w_ic_gnt = w_ic_req;
      w_dc_gnt = w_dc_req && !w_ic_req;
    end else begin
      w_dc_gnt = w_dc_req;
      w_ic_gnt = w_ic_req && !w_dc_req;
    end
  end

  // Memory-side request and per-requester accept responses; quiet in reset.
  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    arb2ic_response  = 4'd0;
    arb2dc_response  = 4'd0;
    if (!reset) begin
      if (w_ic_gnt) begin
        proc2mem_command = ic2arb_command;
        proc2mem_addr    = ic2arb_addr;
        arb2ic_response  = mem2proc_response;
      end else if (w_dc_gnt) begin
        proc2mem_command = dc2arb_command;
        proc2mem_addr    = dc2arb_addr;
        proc2mem_data    = dc2arb_data;
        arb2dc_response  = mem2proc_response;
      end
    end
  end

  // Route returning load data to whichever requester owns the tag.
  always_comb begin
    arb2ic_data = '0;
    arb2ic_tag  = 4'd0;
    arb2dc_data = '0;
    arb2dc_tag  = 4'd0;
    if (!reset && w_ret_hit) begin
      if (w_ret_owner == OWNER_DC) begin
        arb2dc_data = mem2proc_data;
        arb2dc_tag  = mem2proc_tag;
      end else begin
        arb2ic_data = mem2proc_data;
        arb2ic_tag  = mem2proc_tag;
      end
    end
  end

  assign w_accept   = (mem2proc_response != 4'd0);
  assign w_load_set = w_accept &&
                      ((w_ic_gnt && ic2arb_command == BUS_LOAD) ||
                       (w_dc_gnt && dc2arb_command == BUS_LOAD));

  // Starvation counting and state transitions; a denial on the last count forces icache.
  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = 4'd0;
    if (w_ic_req && !w_ic_gnt) begin
      w_starve_nxt = r_starve_cnt + 4'd1;
      if (r_state == ARB_DPRI && r_starve_cnt == STARVE_LAST) begin
        w_state_nxt = ARB_IFORCE;
      end
    end
    if (r_state == ARB_IFORCE && w_ic_gnt && w_accept) begin
      w_state_nxt = ARB_DPRI;
    end
  end

  // Sticky error: unknown tag returned, or live tag re-issued without being freed.
  always_comb begin
    w_err_nxt = r_tag_error;
    if (mem2proc_tag != 4'd0 && !w_ret_hit) begin
      w_err_nxt = 1'b1;
    end
    if (w_load_set && w_set_busy && !(w_ret_hit && mem2proc_tag == mem2proc_response)) begin
      w_err_nxt = 1'b1;
    end
  end

  // Arbitration state, starvation counter and error flag registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ARB_DPRI;
      r_starve_cnt <= 4'd0;
      r_tag_error  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_tag_error  <= w_err_nxt;
    end
  end

  assign tag_error = r_tag_error;

  tag_owner_table #(
    .NUM_TAGS (NUM_TAGS)
  ) u_tag_owner_table (
    .clock     (clock),
    .reset     (reset),
    .set_en    (w_load_set),
    .set_tag   (mem2proc_response),
    .set_owner (w_dc_gnt),
    .ret_tag   (mem2proc_tag),
    .ret_hit   (w_ret_hit),
    .ret_owner (w_ret_owner),
    .set_busy  (w_set_busy),
    .ic_count  (ic_outstanding),
    .dc_count  (dc_outstanding)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic compared against a tag-table reference model.
module tb_mem_arbiter;
  import sys_defs::*;

  localparam int STARVE_LIMIT = 8;
  localparam int NUM_TAGS     = 15;

  logic            clock = 1'b0;
  logic            reset;
  bus_cmd_t        ic2arb_command;
  logic [XLEN-1:0] ic2arb_addr;
  bus_cmd_t        dc2arb_command;
  logic [XLEN-1:0] dc2arb_addr;
  logic [63:0]     dc2arb_data;
  bus_cmd_t        proc2mem_command;
  logic [XLEN-1:0] proc2mem_addr;
  logic [63:0]     proc2mem_data;
  logic [3:0]      mem2proc_response;
  logic [63:0]     mem2proc_data;
  logic [3:0]      mem2proc_tag;
  logic [3:0]      arb2ic_response;
  logic [3:0]      arb2dc_response;
  logic [63:0]     arb2ic_data;
  logic [63:0]     arb2dc_data;
  logic [3:0]      arb2ic_tag;
  logic [3:0]      arb2dc_tag;
  logic [3:0]      ic_outstanding;
  logic [3:0]      dc_outstanding;
  logic            tag_error;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_force;
  int m_starve;
  bit m_valid[16];
  bit m_dc_own[16];
  bit m_err;
  bit m_ic_win;
  bit m_dc_win;

  bus_cmd_t        exp_cmd;
  logic [XLEN-1:0] exp_addr;
  logic [63:0]     exp_data;
  logic [3:0]      exp_ic_resp, exp_dc_resp, exp_ic_tag, exp_dc_tag;
  logic [63:0]     exp_ic_data, exp_dc_data;
  logic [3:0]      exp_ic_out, exp_dc_out;
  logic            exp_err;

  mem_arbiter #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .NUM_TAGS     (NUM_TAGS)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .ic2arb_command    (ic2arb_command),
    .ic2arb_addr       (ic2arb_addr),
    .dc2arb_command    (dc2arb_command),
    .dc2arb_addr       (dc2arb_addr),
    .dc2arb_data       (dc2arb_data),
    .proc2mem_command  (proc2mem_command),
    .proc2mem_addr     (proc2mem_addr),
    .proc2mem_data     (proc2mem_data),
    .mem2proc_response (mem2proc_response),
    .mem2proc_data     (mem2proc_data),
    .mem2proc_tag      (mem2proc_tag),
    .arb2ic_response   (arb2ic_response),
    .arb2dc_response   (arb2dc_response),
    .arb2ic_data       (arb2ic_data),
    .arb2dc_data       (arb2dc_data),
    .arb2ic_tag        (arb2ic_tag),
    .arb2dc_tag        (arb2dc_tag),
    .ic_outstanding    (ic_outstanding),
    .dc_outstanding    (dc_outstanding),
    .tag_error         (tag_error)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic drive_idle();
    ic2arb_command    = BUS_NONE;
    ic2arb_addr       = '0;
    dc2arb_command    = BUS_NONE;
    dc2arb_addr       = '0;
    dc2arb_data       = '0;
    mem2proc_response = 4'd0;
    mem2proc_data     = '0;
    mem2proc_tag      = 4'd0;
  endtask

  task automatic model_reset();
    m_force  = 1'b0;
    m_starve = 0;
    m_err    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      m_valid[i]  = 1'b0;
      m_dc_own[i] = 1'b0;
    end
  endtask

  // Expected outputs from the current model state and driven inputs.
  task automatic model_eval();
    bit ic_req, dc_req;
    int nic, ndc, t;
    ic_req   = (ic2arb_command != BUS_NONE);
    dc_req   = (dc2arb_command != BUS_NONE);
    m_ic_win = m_force ? ic_req : (ic_req && !dc_req);
    m_dc_win = dc_req && !m_ic_win;
    exp_cmd = BUS_NONE; exp_addr = '0; exp_data = '0;
    exp_ic_resp = 0; exp_dc_resp = 0; exp_ic_tag = 0; exp_dc_tag = 0;
    exp_ic_data = '0; exp_dc_data = '0;
    nic = 0; ndc = 0;
    for (int i = 1; i < 16; i++) begin
      if (m_valid[i] && m_dc_own[i]) ndc++;
      if (m_valid[i] && !m_dc_own[i]) nic++;
    end
    exp_ic_out = 4'(nic);
    exp_dc_out = 4'(ndc);
    exp_err    = m_err;
    if (!reset) begin
      if (m_ic_win) begin
        exp_cmd = ic2arb_command; exp_addr = ic2arb_addr; exp_ic_resp = mem2proc_response;
      end else if (m_dc_win) begin
        exp_cmd = dc2arb_command; exp_addr = dc2arb_addr; exp_data = dc2arb_data;
        exp_dc_resp = mem2proc_response;
      end
      t = int'(mem2proc_tag);
      if (t != 0 && m_valid[t]) begin
        if (m_dc_own[t]) begin exp_dc_data = mem2proc_data; exp_dc_tag = mem2proc_tag; end
        else begin exp_ic_data = mem2proc_data; exp_ic_tag = mem2proc_tag; end
      end
    end
  endtask

  // Advance the model across one clock edge.
  task automatic model_commit();
    bit acc, hit, old_force;
    int t, r;
    model_eval();
    old_force = m_force;
    t   = int'(mem2proc_tag);
    r   = int'(mem2proc_response);
    acc = (r != 0) && ((m_ic_win && ic2arb_command == BUS_LOAD) ||
                       (m_dc_win && dc2arb_command == BUS_LOAD));
    hit = (t != 0) && m_valid[t];
    if (t != 0 && !hit) m_err = 1'b1;
    if (acc && m_valid[r] && !(hit && t == r)) m_err = 1'b1;
    if (hit) m_valid[t] = 1'b0;
    if (acc) begin
      m_valid[r]  = 1'b1;
      m_dc_own[r] = m_dc_win;
    end
    if (ic2arb_command != BUS_NONE && !m_ic_win) begin
      m_starve++;
      if (!old_force && m_starve == STARVE_LIMIT) m_force = 1'b1;
    end else begin
      m_starve = 0;
    end
    if (old_force && m_ic_win && r != 0) m_force = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    if (!reset) model_commit();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_idle();
    model_reset();
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    ic2arb_command = BUS_LOAD; ic2arb_addr = 32'h1111_0000;
    dc2arb_command = BUS_STORE; dc2arb_addr = 32'h2222_0000; dc2arb_data = 64'hFACE;
    mem2proc_response = 4'd3; mem2proc_tag = 4'd5; mem2proc_data = 64'h55;
    #2;
    checks++; if (proc2mem_command !== BUS_NONE) begin errors++; $display("FAIL rst_cmd got=%0d exp=0", proc2mem_command); end
    checks++; if (proc2mem_addr !== '0) begin errors++; $display("FAIL rst_addr got=%0h exp=0", proc2mem_addr); end
    checks++; if (proc2mem_data !== '0) begin errors++; $display("FAIL rst_data got=%0h exp=0", proc2mem_data); end
    checks++; if (arb2ic_response !== 4'd0) begin errors++; $display("FAIL rst_ic_resp got=%0h exp=0", arb2ic_response); end
    checks++; if (arb2dc_response !== 4'd0) begin errors++; $display("FAIL rst_dc_resp got=%0h exp=0", arb2dc_response); end
    checks++; if (arb2ic_tag !== 4'd0 || arb2ic_data !== '0) begin errors++; $display("FAIL rst_ic_ret got=%0h/%0h exp=0/0", arb2ic_tag, arb2ic_data); end
    checks++; if (arb2dc_tag !== 4'd0 || arb2dc_data !== '0) begin errors++; $display("FAIL rst_dc_ret got=%0h/%0h exp=0/0", arb2dc_tag, arb2dc_data); end
    checks++; if (ic_outstanding !== 4'd0 || dc_outstanding !== 4'd0) begin errors++; $display("FAIL rst_outstanding got=%0d/%0d exp=0/0", ic_outstanding, dc_outstanding); end
    checks++; if (tag_error !== 1'b0) begin errors++; $display("FAIL rst_tag_error got=%0b exp=0", tag_error); end
    drive_idle();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_dc_priority();
    do_reset();
    ic2arb_command = BUS_LOAD; ic2arb_addr = 32'h0000_1000;
    dc2arb_command = BUS_LOAD; dc2arb_addr = 32'h0000_2000;
    mem2proc_response = 4'd3;
    #2;
    checks++; if (proc2mem_addr !== 32'h0000_2000) begin errors++; $display("FAIL dcpri_addr got=%0h exp=2000", proc2mem_addr); end
    checks++; if (arb2dc_response !== 4'd3) begin errors++; $display("FAIL dcpri_dc_resp got=%0h exp=3", arb2dc_response); end
    checks++; if (arb2ic_response !== 4'd0) begin errors++; $display("FAIL dcpri_ic_resp got=%0h exp=0", arb2ic_response); end
    tick();
    drive_idle();
    mem2proc_tag = 4'd3; mem2proc_data = 64'hDEAD;
    #2;
    checks++; if (dc_outstanding !== 4'd1) begin errors++; $display("FAIL dcpri_dc_out got=%0d exp=1", dc_outstanding); end
    checks++; if (arb2dc_data !== 64'hDEAD) begin errors++; $display("FAIL dcpri_dc_data got=%0h exp=dead", arb2dc_data); end
    checks++; if (arb2dc_tag !== 4'd3) begin errors++; $display("FAIL dcpri_dc_tag got=%0h exp=3", arb2dc_tag); end
    checks++; if (arb2ic_tag !== 4'd0) begin errors++; $display("FAIL dcpri_ic_tag got=%0h exp=0", arb2ic_tag); end
    tick();
    drive_idle();
    #2;
    checks++; if (dc_outstanding !== 4'd0) begin errors++; $display("FAIL dcpri_dc_out_clr got=%0d exp=0", dc_outstanding); end
    checks++; if (tag_error !== 1'b0) begin errors++; $display("FAIL dcpri_tag_error got=%0b exp=0", tag_error); end
  endtask

  task automatic test_starvation();
    do_reset();
    ic2arb_command = BUS_LOAD; ic2arb_addr = 32'h100;
    dc2arb_command = BUS_STORE; dc2arb_addr = 32'h200; dc2arb_data = 64'h77;
    mem2proc_response = 4'd1;
    for (int c = 1; c <= 8; c++) begin
      #2;
      checks++; if (proc2mem_command !== BUS_STORE || arb2ic_response !== 4'd0) begin
        errors++; $display("FAIL starve_dc_c%0d got=%0d/%0h exp=2/0", c, proc2mem_command, arb2ic_response);
      end
      tick();
    end
    #2;
    checks++; if (proc2mem_command !== BUS_LOAD || proc2mem_addr !== 32'h100) begin
      errors++; $display("FAIL starve_ic_c9 got=%0d/%0h exp=1/100", proc2mem_command, proc2mem_addr);
    end
    checks++; if (arb2ic_response !== 4'd1 || arb2dc_response !== 4'd0) begin
      errors++; $display("FAIL starve_resp_c9 got=%0h/%0h exp=1/0", arb2ic_response, arb2dc_response);
    end
    tick();
    #2;
    checks++; if (proc2mem_command !== BUS_STORE) begin errors++; $display("FAIL starve_back_dpri got=%0d exp=2", proc2mem_command); end
    tick();
  endtask

  task automatic test_iforce_retry();
    do_reset();
    ic2arb_command = BUS_LOAD; ic2arb_addr = 32'h300;
    dc2arb_command = BUS_STORE; dc2arb_addr = 32'h400;
    mem2proc_response = 4'd0;
    for (int c = 1; c <= 8; c++) tick();
    for (int c = 9; c <= 11; c++) begin
      #2;
      checks++; if (proc2mem_command !== BUS_LOAD || arb2ic_response !== 4'd0 || arb2dc_response !== 4'd0) begin
        errors++; $display("FAIL retry_c%0d got=%0d/%0h/%0h exp=1/0/0", c, proc2mem_command, arb2ic_response, arb2dc_response);
      end
      tick();
    end
    mem2proc_response = 4'd5;
    #2;
    checks++; if (proc2mem_command !== BUS_LOAD || arb2ic_response !== 4'd5) begin
      errors++; $display("FAIL retry_accept got=%0d/%0h exp=1/5", proc2mem_command, arb2ic_response);
    end
    tick();
    mem2proc_response = 4'd0;
    #2;
    checks++; if (proc2mem_command !== BUS_STORE) begin errors++; $display("FAIL retry_back_dpri got=%0d exp=2", proc2mem_command); end
    checks++; if (ic_outstanding !== 4'd1) begin errors++; $display("FAIL retry_ic_out got=%0d exp=1", ic_outstanding); end
    tick();
  endtask

  task automatic test_store_error();
    do_reset();
    dc2arb_command = BUS_STORE; dc2arb_addr = 32'h500; dc2arb_data = 64'hC0FFEE;
    mem2proc_response = 4'd2;
    #2;
    checks++; if (arb2dc_response !== 4'd2 || proc2mem_data !== 64'hC0FFEE) begin
      errors++; $display("FAIL store_accept got=%0h/%0h exp=2/c0ffee", arb2dc_response, proc2mem_data);
    end
    tick();
    drive_idle();
    mem2proc_tag = 4'd2; mem2proc_data = 64'hBEEF;
    #2;
    checks++; if (arb2dc_tag !== 4'd0 || arb2ic_tag !== 4'd0 || arb2dc_data !== '0 || arb2ic_data !== '0) begin
      errors++; $display("FAIL store_noroute got=%0h/%0h exp=0/0", arb2dc_tag, arb2ic_tag);
    end
    checks++; if (dc_outstanding !== 4'd0) begin errors++; $display("FAIL store_dc_out got=%0d exp=0", dc_outstanding); end
    tick();
    drive_idle();
    #2;
    checks++; if (tag_error !== 1'b1) begin errors++; $display("FAIL store_tag_error got=%0b exp=1", tag_error); end
  endtask

  task automatic test_reset_mid_stream();
    do_reset();
    ic2arb_command = BUS_LOAD; ic2arb_addr = 32'h600; mem2proc_response = 4'd1;
    tick();
    mem2proc_response = 4'd2;
    tick();
    drive_idle();
    #2;
    checks++; if (ic_outstanding !== 4'd2) begin errors++; $display("FAIL midrst_before got=%0d exp=2", ic_outstanding); end
    reset = 1'b1;
    model_reset();
    #1;
    checks++; if (ic_outstanding !== 4'd0) begin errors++; $display("FAIL midrst_ic_out got=%0d exp=0", ic_outstanding); end
    tick();
    reset = 1'b0;
    mem2proc_tag = 4'd1; mem2proc_data = 64'h99;
    #2;
    checks++; if (arb2ic_tag !== 4'd0 || arb2dc_tag !== 4'd0) begin errors++; $display("FAIL midrst_noroute got=%0h/%0h exp=0/0", arb2ic_tag, arb2dc_tag); end
    tick();
    drive_idle();
    #2;
    checks++; if (tag_error !== 1'b1) begin errors++; $display("FAIL midrst_tag_error got=%0b exp=1", tag_error); end
  endtask

  task automatic test_same_cycle_reissue();
    do_reset();
    ic2arb_command = BUS_LOAD; ic2arb_addr = 32'h700; mem2proc_response = 4'd4;
    tick();
    drive_idle();
    dc2arb_command = BUS_LOAD; dc2arb_addr = 32'h800;
    mem2proc_response = 4'd4; mem2proc_tag = 4'd4; mem2proc_data = 64'h1234;
    #2;
    checks++; if (arb2ic_tag !== 4'd4 || arb2ic_data !== 64'h1234) begin
      errors++; $display("FAIL reissue_old_owner got=%0h/%0h exp=4/1234", arb2ic_tag, arb2ic_data);
    end
    checks++; if (arb2dc_tag !== 4'd0 || arb2dc_response !== 4'd4) begin
      errors++; $display("FAIL reissue_dc got=%0h/%0h exp=0/4", arb2dc_tag, arb2dc_response);
    end
    tick();
    drive_idle();
    mem2proc_tag = 4'd4; mem2proc_data = 64'h5678;
    #2;
    checks++; if (ic_outstanding !== 4'd0 || dc_outstanding !== 4'd1) begin
      errors++; $display("FAIL reissue_counts got=%0d/%0d exp=0/1", ic_outstanding, dc_outstanding);
    end
    checks++; if (arb2dc_tag !== 4'd4 || arb2ic_tag !== 4'd0) begin
      errors++; $display("FAIL reissue_new_owner got=%0h/%0h exp=4/0", arb2dc_tag, arb2ic_tag);
    end
    tick();
    drive_idle();
  endtask

  task automatic test_random();
    int r, start, pick;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      r = $urandom_range(0, 99);
      ic2arb_command = (r < 65) ? BUS_LOAD : BUS_NONE;
      r = $urandom_range(0, 3);
      dc2arb_command = (r == 0) ? BUS_NONE : ((r == 1) ? BUS_STORE : BUS_LOAD);
      ic2arb_addr = $urandom;
      dc2arb_addr = $urandom;
      dc2arb_data = {$urandom, $urandom};
      mem2proc_data = {$urandom, $urandom};
      r = $urandom_range(0, 3);
      mem2proc_response = (r == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      r = $urandom_range(0, 9);
      pick = 0;
      if (r >= 4 && r < 9) begin
        start = $urandom_range(1, 15);
        for (int k = 0; k < 15; k++) begin
          if (pick == 0 && m_valid[((start + k - 1) % 15) + 1]) pick = ((start + k - 1) % 15) + 1;
        end
      end else if (r == 9) begin
        pick = $urandom_range(1, 15);
      end
      mem2proc_tag = 4'(pick);
      model_eval();
      #2;
      checks++; if (proc2mem_command !== exp_cmd) begin errors++; $display("FAIL rnd_cmd c=%0d got=%0d exp=%0d", c, proc2mem_command, exp_cmd); end
      checks++; if (proc2mem_addr !== exp_addr) begin errors++; $display("FAIL rnd_addr c=%0d got=%0h exp=%0h", c, proc2mem_addr, exp_addr); end
      checks++; if (proc2mem_data !== exp_data) begin errors++; $display("FAIL rnd_data c=%0d got=%0h exp=%0h", c, proc2mem_data, exp_data); end
      checks++; if (arb2ic_response !== exp_ic_resp) begin errors++; $display("FAIL rnd_ic_resp c=%0d got=%0h exp=%0h", c, arb2ic_response, exp_ic_resp); end
      checks++; if (arb2dc_response !== exp_dc_resp) begin errors++; $display("FAIL rnd_dc_resp c=%0d got=%0h exp=%0h", c, arb2dc_response, exp_dc_resp); end
      checks++; if (arb2ic_tag !== exp_ic_tag) begin errors++; $display("FAIL rnd_ic_tag c=%0d got=%0h exp=%0h", c, arb2ic_tag, exp_ic_tag); end
      checks++; if (arb2dc_tag !== exp_dc_tag) begin errors++; $display("FAIL rnd_dc_tag c=%0d got=%0h exp=%0h", c, arb2dc_tag, exp_dc_tag); end
      checks++; if (arb2ic_data !== exp_ic_data) begin errors++; $display("FAIL rnd_ic_data c=%0d got=%0h exp=%0h", c, arb2ic_data, exp_ic_data); end
      checks++; if (arb2dc_data !== exp_dc_data) begin errors++; $display("FAIL rnd_dc_data c=%0d got=%0h exp=%0h", c, arb2dc_data, exp_dc_data); end
      checks++; if (ic_outstanding !== exp_ic_out) begin errors++; $display("FAIL rnd_ic_out c=%0d got=%0d exp=%0d", c, ic_outstanding, exp_ic_out); end
      checks++; if (dc_outstanding !== exp_dc_out) begin errors++; $display("FAIL rnd_dc_out c=%0d got=%0d exp=%0d", c, dc_outstanding, exp_dc_out); end
      checks++; if (tag_error !== exp_err) begin errors++; $display("FAIL rnd_tag_error c=%0d got=%0b exp=%0b", c, tag_error, exp_err); end
      tick();
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    reset = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
    test_reset();
    test_dc_priority();
    test_starvation();
    test_iforce_retry();
    test_store_error();
    test_reset_mid_stream();
    test_same_cycle_reissue();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 8: consecutive icache denials that force an icache grant.
REQ-002 Parameter NUM_TAGS, default 15: usable memory tags 1..15; tag 0 means none.
REQ-003 clock  in  1  single clock; all state on posedge clock.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 ic2arb_command  in  2  icache request: BUS_NONE or BUS_LOAD.
REQ-006 ic2arb_addr  in  XLEN  icache request address.
REQ-007 dc2arb_command  in  2  dcache request: BUS_NONE, BUS_LOAD or BUS_STORE.
REQ-008 dc2arb_addr  in  XLEN  dcache address; dc2arb_data  in  64  store data.
REQ-009 proc2mem_command  out  2; proc2mem_addr  out  XLEN; proc2mem_data  out  64  to memory.
REQ-010 mem2proc_response  in  4  tag accepted this cycle, 0 = rejected; mem2proc_data  in  64; mem2proc_tag  in  4  returning-data tag.
REQ-011 arb2ic_response / arb2dc_response  out  4  per-requester accept tag.
REQ-012 arb2ic_data / arb2dc_data  out  64; arb2ic_tag / arb2dc_tag  out  4  per-requester data return.
REQ-013 ic_outstanding / dc_outstanding  out  4  live loads owned by each requester.
REQ-014 tag_error  out  1  sticky protocol-error flag.

Function
REQ-015 Grant is combinational each cycle; the granted request drives proc2mem_* in the same cycle.
REQ-016 State ARB_DPRI: dcache wins if its command != BUS_NONE, else icache.
REQ-017 State ARB_IFORCE: icache wins if requesting, else dcache.
REQ-018 starve_cnt (4 bits) increments when icache requests and is not granted; it clears when icache is granted or not requesting.
REQ-019 ARB_DPRI -> ARB_IFORCE when starve_cnt reaches STARVE_LIMIT-1 while incrementing; ARB_IFORCE -> ARB_DPRI after any cycle where icache is granted and mem2proc_response != 0.
REQ-020 In ARB_IFORCE with mem2proc_response == 0, the grant holds on icache (retry) and the state does not change.
REQ-021 With no request, proc2mem_command = BUS_NONE, proc2mem_addr = 0 and proc2mem_data = 0.
REQ-022 proc2mem_data is dc2arb_data when dcache is granted, else 0.
REQ-023 The granted requester's response equals mem2proc_response; the other requester's response is 0 in the same cycle.
REQ-024 Owner table: when a BUS_LOAD is accepted (response != 0), the entry for that tag is set valid with its owner on the next edge. BUS_STORE acceptances are not recorded.
REQ-025 When mem2proc_tag != 0 and the entry is valid, the arbiter drives the owner's data/tag outputs with mem2proc_data/mem2proc_tag and the other requester's tag output to 0. The entry clears on the next edge.
REQ-026 When mem2proc_tag hits an invalid entry, no requester receives data and tag_error sets.
REQ-027 When an accepted load's tag is already valid, tag_error sets and the entry is overwritten with the new owner.
REQ-028 When the same tag is returned and re-issued in one cycle, the set wins: the entry stays valid with the new owner.
REQ-029 ic_outstanding / dc_outstanding equal the registered count of valid entries per owner; they never exceed NUM_TAGS.

Reset
REQ-030 On reset assertion, at any time including mid-transaction:
- state = ARB_DPRI, starve_cnt = 0;
- all owner entries invalid, outstanding counts 0, tag_error = 0.
REQ-031 While reset is asserted, all data/tag/response outputs read 0 and proc2mem_command = BUS_NONE.

Structure
REQ-032 The bus command enum (BUS_NONE/BUS_LOAD/BUS_STORE), XLEN and the arbiter state enum live in the shared sys_defs package.
REQ-033 One sub-module, tag_owner_table, holds the 15-entry valid/owner array, set/clear ports, lookup and counts.

Verification
REQ-034 dc BUS_LOAD and ic BUS_LOAD together, response=3 -> dc granted, arb2dc_response=3, arb2ic_response=0; then tag=3 with data 0xDEAD -> arb2dc_data=0xDEAD, arb2dc_tag=3, arb2ic_tag=0.
REQ-035 dc requests continuously and ic requests continuously, STARVE_LIMIT=8 -> ic granted on cycle 9, then state returns to ARB_DPRI.
REQ-036 ARB_IFORCE with response=0 for 3 cycles, then 5 -> ic stays granted throughout; arb2ic_response=5 on the 4th cycle.
REQ-037 dc BUS_STORE accepted with tag 2, then mem2proc_tag=2 -> no owner gets data, tag_error=1.
REQ-038 Two ic loads outstanding, reset pulsed mid-stream -> ic_outstanding=0; a later return of that tag sets tag_error.
REQ-039 Tag 4 returns while a new load is accepted with tag 4 in the same cycle -> data routes to the old owner; entry 4 is valid with the new owner afterwards.
